muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit for MULT, MULTU, DIV, DIVU, MTHI, MTLO; owns the HI/LO registers.
//  Sits beside the single-cycle ALU in EX: it takes the same forwarded operand pair.
//  It returns results through HI/LO (read by MFHI/MFLO) rather than a same-cycle result.
//  While busy is high the hazard unit stalls any instruction that touches HI/LO.
// PARAMETERS
//  WIDTH   32  operand width; HI and LO are each WIDTH bits
// PORTS
//  clk     in   1      rising-edge clock
//  rst     in   1      synchronous, active-low reset
//  start   in   1      launch op; sampled only in IDLE
//  op      in   2      `MDU_MULT=0, `MDU_MULTU=1, `MDU_DIV=2, `MDU_DIVU=3
//  A       in   WIDTH  multiplicand / dividend (rs)
//  B       in   WIDTH  multiplier / divisor (rt)
//  mthi    in   1      write A into HI; honoured only in IDLE
//  mtlo    in   1      write A into LO; honoured only in IDLE
//  busy    out  1      high from the cycle after start is accepted until done
//  done    out  1      one-cycle pulse; HI/LO hold the new result in that cycle
//  hi      out  WIDTH  HI register
//  lo      out  WIDTH  LO register
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge): state=IDLE, cnt=0, hi=lo=0, busy=0, done=0.
//    Reset mid-operation aborts the op with no done pulse; the partial result is discarded.
//  - FSM states: IDLE -> RUN -> FIX -> IDLE.
//    IDLE: on start, latch the operand magnitudes.
//      Signed ops use |A| and |B|, plus the result-sign and remainder-sign flags.
//      Unsigned ops use A and B unchanged.
//      Then cnt=0 and go to RUN.
//    RUN: one radix-2 step per cycle; leave after exactly WIDTH steps (cnt==WIDTH-1) to FIX.
//      MUL: shift-add into a 2*WIDTH accumulator.
//      DIV: restoring division, producing a WIDTH-bit quotient and a WIDTH-bit remainder.
//    FIX: apply signs and write hi/lo; done=1 for this cycle only; go to IDLE.
//  - Timing: start accepted at edge E0.
//    busy=1 from E0 to E0+WIDTH+1; done=1 in the cycle after edge E0+WIDTH+1, with busy=0 then.
//    So for WIDTH=32, busy lasts 33 cycles and done appears in cycle 34.
//  - Signed conventions:
//    Product is the two's-complement 2*WIDTH result, split hi=upper half, lo=lower half.
//    Quotient truncates toward zero; remainder takes the sign of the dividend.
//    DIV 0x80000000 / -1 gives lo=0x80000000, hi=0 (no trap).
//  - Divide by zero (B==0, DIV or DIVU): normal latency; FIX forces hi=A (raw, unsigned view), lo=all ones.
//  - start, mthi and mtlo while busy or in FIX are ignored.
//    The pipeline stalls, so this is a protocol violation, but it must not corrupt state.
//  - In IDLE, start together with mthi or mtlo: start wins and the move is dropped.
//    mthi and mtlo together write both registers.
//  - hi/lo keep their old values throughout RUN and change only in FIX or on a move/reset.
//  - Operands are registered at E0; A and B may change freely after E0.
//  - The 2*WIDTH accumulator has no overflow; unsigned intermediates are WIDTH+1 bits where subtraction needs it.
// STRUCTURE
//  - Add `MDU_MULT/`MDU_MULTU/`MDU_DIV/`MDU_DIVU and the FSM state encodings to ctrl_encode_def.v,
//    alongside the ALU op codes.
//  - One sub-module, mdu_iter_core: holds the accumulator/remainder/quotient registers and performs one step per cycle.
//    Selects the mul or div step; load and step enables come from the FSM.
//  - Sign correction, the divide-by-zero override and the HI/LO registers stay in muldiv_unit.
// TESTING
//  1. MULT A=-3 (0xFFFFFFFD), B=5 -> done in cycle 34 after start; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//  2. MULTU A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  3. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIVU 7/2 -> lo=3, hi=1.
//     DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  4. DIVU A=0x1234, B=0 -> hi=0x00001234, lo=0xFFFFFFFF after the normal 33 busy cycles.
//  5. While busy: start, mthi(A=0xAAAA) and mtlo all ignored.
//     After done: mthi A=0x55 -> hi=0x55 next cycle, lo unchanged.
//     In IDLE, start+mtlo together -> only the op runs.
//  6. rst=0 at cycle 10 of a DIV -> next cycle busy=0, hi=lo=0, and no done pulse ever;
//     a new MULT 6*7 then gives lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, FSM encodings and op-decode helpers for the iterative multiply/divide unit.
package muldiv_unit_pkg;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'd0,
      MDU_MULTU = 2'd1,
      MDU_DIV   = 2'd2,
      MDU_DIVU  = 2'd3
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } mdu_state_e;

   function automatic logic op_is_div(input mdu_op_e op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   function automatic logic op_is_signed(input mdu_op_e op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Operand/control bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
);
   logic             start;
   mdu_op_e          op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             mthi;
   logic             mtlo;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, mthi, mtlo,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, mthi, mtlo,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/mdu_iter_core.sv
// Radix-2 datapath: shift-add multiply or restoring divide, one step per enabled cycle.
module mdu_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   // Multiply: acc = {partial, multiplier}, opr = multiplicand.
   // Divide:   acc = {remainder, dividend/quotient}, opr = divisor.
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opr;
   logic               div_mode;

   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     trial;
   logic [WIDTH-1:0]   diff;
   logic               fits;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] div_next;

   always_comb begin
      add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opr};
      mul_next = acc[0] ? {add_sum, acc[WIDTH-1:1]}
                        : {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
      // Remainder stays below the divisor, so the accepted difference fits in WIDTH bits.
      trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      fits     = (trial >= {1'b0, opr});
      diff     = trial[WIDTH-1:0] - opr;
      div_next = fits ? {diff, acc[WIDTH-2:0], 1'b1}
                      : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
   end

   always_ff @(posedge clk) begin
      if (load) begin
         acc      <= is_div ? {{WIDTH{1'b0}}, opa} : {{WIDTH{1'b0}}, opb};
         opr      <= is_div ? opb : opa;
         div_mode <= is_div;
      end else if (step) begin
         acc <= div_mode ? div_next : mul_next;
      end
   end

   assign res_hi = acc[2*WIDTH-1:WIDTH];
   assign res_lo = acc[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; results appear after WIDTH+1 busy cycles.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst,
   muldiv_unit_if.slave bus
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   mdu_state_e       state, state_nxt;
   logic [CW-1:0]    cnt;
   logic             load, step;
   logic             done_r;
   logic [WIDTH-1:0] hi_r, lo_r;

   mdu_op_e          op_q;
   logic             neg_q, neg_r, b_zero;
   logic [WIDTH-1:0] a_raw;

   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] core_hi, core_lo;
   logic [WIDTH-1:0] fix_hi, fix_lo;

   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                  input logic sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   assign a_mag = magnitude(bus.a, op_is_signed(bus.op));
   assign b_mag = magnitude(bus.b, op_is_signed(bus.op));

   mdu_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .load   (load),
      .step   (step),
      .is_div (op_is_div(bus.op)),
      .opa    (a_mag),
      .opb    (b_mag),
      .res_hi (core_hi),
      .res_lo (core_lo)
   );

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         ST_IDLE: if (bus.start) begin
            load      = 1'b1;
            state_nxt = ST_RUN;
         end
         ST_RUN: begin
            step = 1'b1;
            if (cnt == LAST) state_nxt = ST_FIX;
         end
         ST_FIX:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Sign correction and the divide-by-zero override, consumed only in FIX.
   always_comb begin
      fix_hi = core_hi;
      fix_lo = core_lo;
      if (!op_is_div(op_q)) begin
         {fix_hi, fix_lo} = cond_neg2({core_hi, core_lo}, neg_q);
      end else if (b_zero) begin
         fix_hi = a_raw;
         fix_lo = '1;
      end else begin
         fix_lo = cond_neg(core_lo, neg_q);
         fix_hi = cond_neg(core_hi, neg_r);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         done_r <= 1'b0;
         hi_r   <= '0;
         lo_r   <= '0;
      end else begin
         state  <= state_nxt;
         done_r <= (state == ST_FIX);
         if (load)      cnt <= '0;
         else if (step) cnt <= cnt + CW'(1);
         if (state == ST_FIX) begin
            hi_r <= fix_hi;
            lo_r <= fix_lo;
         end else if (state == ST_IDLE && !bus.start) begin
            if (bus.mthi) hi_r <= bus.a;
            if (bus.mtlo) lo_r <= bus.a;
         end
      end
   end

   // Operand-side flags are captured at launch so A/B may change during the op.
   always_ff @(posedge clk) begin
      if (load) begin
         op_q   <= bus.op;
         neg_q  <= op_is_signed(bus.op) && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
         neg_r  <= op_is_signed(bus.op) && bus.a[WIDTH-1];
         a_raw  <= bus.a;
         b_zero <= (bus.b == '0);
      end
   end

   assign bus.busy = (state != ST_IDLE);
   assign bus.done = done_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed table-driven bench for muldiv_unit plus hand-written protocol and reset sequences.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   localparam int W = 32;

   typedef struct {
      mdu_op_e      op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_hi;
      logic [W-1:0] exp_lo;
   } vec_t;

   logic clk;
   logic rst;
   int   n_total;
   int   n_pass;

   muldiv_unit_if #(.WIDTH(W)) bus ();

   muldiv_unit #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Caller is 1 time unit after an edge; counts edges until done (lat) and busy cycles seen.
   task automatic wait_done(output int lat, output int busy_cnt);
      lat      = -1;
      busy_cnt = 0;
      for (int k = 0; k < 100; k++) begin
         if (bus.done) begin
            lat = k;
            break;
         end
         if (bus.busy) busy_cnt++;
         tick();
      end
   endtask

   vec_t vecs[12];
   int   lat, bcnt;
   logic seen;

   initial begin
      n_total = 0;
      n_pass  = 0;
      vecs[0]  = '{MDU_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[1]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{MDU_DIVU,  32'd7,        32'd2,        32'd1,        32'd3};
      vecs[4]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5]  = '{MDU_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
      vecs[6]  = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      vecs[7]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[8]  = '{MDU_MULT,  32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
      vecs[9]  = '{MDU_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[10] = '{MDU_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF};
      vecs[11] = '{MDU_MULTU, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000};

      rst = 1'b0;
      bus.start = 1'b0;
      bus.op    = MDU_MULT;
      bus.a     = '0;
      bus.b     = '0;
      bus.mthi  = 1'b0;
      bus.mtlo  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_done", 64'(bus.done), 64'd0);
      chk("reset_hi",   64'(bus.hi),   64'd0);
      chk("reset_lo",   64'(bus.lo),   64'd0);
      rst = 1'b1;
      tick();

      for (int i = 0; i < 12; i++) begin
         bus.op    = vecs[i].op;
         bus.a     = vecs[i].a;
         bus.b     = vecs[i].b;
         bus.start = 1'b1;
         tick();
         bus.start = 1'b0;
         bus.a     = $urandom;
         bus.b     = $urandom;
         wait_done(lat, bcnt);
         chk($sformatf("v%0d_latency", i), 64'(lat), 64'd33);
         chk($sformatf("v%0d_busycyc", i), 64'(bcnt), 64'd33);
         chk($sformatf("v%0d_busy_at_done", i), 64'(bus.busy), 64'd0);
         chk($sformatf("v%0d_hi", i), 64'(bus.hi), 64'(vecs[i].exp_hi));
         chk($sformatf("v%0d_lo", i), 64'(bus.lo), 64'(vecs[i].exp_lo));
         tick();
         chk($sformatf("v%0d_done_pulse", i), 64'(bus.done), 64'd0);
      end

      // mthi+mtlo together write both registers
      bus.a    = 32'h1111;
      bus.mthi = 1'b1;
      bus.mtlo = 1'b1;
      tick();
      bus.mthi = 1'b0;
      bus.mtlo = 1'b0;
      chk("mt_both_hi", 64'(bus.hi), 64'h1111);
      chk("mt_both_lo", 64'(bus.lo), 64'h1111);

      // Start, mthi, mtlo held through RUN and FIX must all be ignored
      bus.op    = MDU_DIVU;
      bus.a     = 32'd100;
      bus.b     = 32'd7;
      bus.start = 1'b1;
      tick();
      bus.op   = MDU_MULT;
      bus.a    = 32'hAAAA;
      bus.b    = 32'd3;
      bus.mthi = 1'b1;
      bus.mtlo = 1'b1;
      lat = -1;
      for (int k = 0; k < 100; k++) begin
         if (bus.done) begin
            lat = k;
            break;
         end
         if (k == 10) begin
            chk("run_hold_hi", 64'(bus.hi), 64'h1111);
            chk("run_hold_lo", 64'(bus.lo), 64'h1111);
         end
         tick();
      end
      bus.start = 1'b0;
      bus.mthi  = 1'b0;
      bus.mtlo  = 1'b0;
      chk("busy_ign_latency", 64'(lat), 64'd33);
      chk("busy_ign_hi", 64'(bus.hi), 64'd2);
      chk("busy_ign_lo", 64'(bus.lo), 64'd14);
      tick();
      chk("busy_ign_no_relaunch", 64'(bus.busy), 64'd0);
      chk("busy_ign_hi_kept", 64'(bus.hi), 64'd2);

      // mthi after done
      bus.a    = 32'h55;
      bus.mthi = 1'b1;
      tick();
      bus.mthi = 1'b0;
      chk("mthi_hi", 64'(bus.hi), 64'h55);
      chk("mthi_lo_kept", 64'(bus.lo), 64'd14);

      // start+mtlo in IDLE: op runs, move dropped
      bus.op    = MDU_MULTU;
      bus.a     = 32'd3;
      bus.b     = 32'd4;
      bus.start = 1'b1;
      bus.mtlo  = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.mtlo  = 1'b0;
      chk("start_mtlo_lo_kept", 64'(bus.lo), 64'd14);
      chk("start_mtlo_busy", 64'(bus.busy), 64'd1);
      wait_done(lat, bcnt);
      chk("start_mtlo_latency", 64'(lat), 64'd33);
      chk("start_mtlo_hi", 64'(bus.hi), 64'd0);
      chk("start_mtlo_lo", 64'(bus.lo), 64'd12);
      tick();

      // Reset in cycle 10 of a DIV aborts it with no done pulse
      bus.op    = MDU_DIV;
      bus.a     = 32'd100;
      bus.b     = 32'd7;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (9) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_done", 64'(bus.done), 64'd0);
      chk("abort_hi", 64'(bus.hi), 64'd0);
      chk("abort_lo", 64'(bus.lo), 64'd0);
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (bus.done || bus.busy) seen = 1'b1;
         tick();
      end
      chk("abort_no_done", 64'(seen), 64'd0);

      bus.op    = MDU_MULT;
      bus.a     = 32'd6;
      bus.b     = 32'd7;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_done(lat, bcnt);
      chk("post_reset_latency", 64'(lat), 64'd33);
      chk("post_reset_hi", 64'(bus.hi), 64'd0);
      chk("post_reset_lo", 64'(bus.lo), 64'd42);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
